// File: rtl/mem_stage.sv
// Memory-access stage: issues aligned doubleword cache requests for loads/stores,
// extracts and extends load data, and hands writeback a registered result bundle.
module mem_stage #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned REGBITS = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    in_alures,
  input  logic [XLEN-1:0]    in_store_data,
  input  logic [REGBITS-1:0] in_rd,
  input  logic               in_wen,
  input  logic               in_is_load,
  input  logic               in_is_store,
  input  logic [2:0]         in_funct3,
  output logic               dc_req_valid,
  input  logic               dc_req_ready,
  output logic [XLEN-1:0]    dc_req_addr,
  output logic               dc_req_we,
  output logic [XLEN-1:0]    dc_req_wdata,
  output logic [7:0]         dc_req_wstrb,
  input  logic               dc_resp_valid,
  input  logic [XLEN-1:0]    dc_resp_data,
  output logic               out_valid,
  output logic [XLEN-1:0]    out_lddata,
  output logic [XLEN-1:0]    out_alures,
  output logic               out_ld_or_alu,
  output logic [REGBITS-1:0] out_rd,
  output logic               out_wen,
  output logic               out_fault
);

  localparam int unsigned OFFW = 3;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t              state;
  logic [OFFW-1:0]     off_q;
  logic [2:0]          f3_q;
  logic [REGBITS-1:0]  rd_q;
  logic                wen_q;
  logic                is_load_q;
  logic [XLEN-1:0]     alures_q;

  logic [OFFW-1:0]     in_off_c;
  logic [OFFW-1:0]     align_mask_c;
  logic [7:0]          size_strb_c;
  logic                misaligned_c;
  logic [XLEN-1:0]     wdata_c;
  logic [7:0]          wstrb_c;
  logic [XLEN-1:0]     shifted_c;
  logic [XLEN-1:0]     ext_c;

  // Size decode for the incoming access: alignment mask and byte-enable pattern
  always_comb begin
    in_off_c     = in_alures[OFFW-1:0];
    align_mask_c = 3'b000;
    size_strb_c  = 8'h01;
    case (in_funct3[1:0])
      2'b00: begin align_mask_c = 3'b000; size_strb_c = 8'h01; end
      2'b01: begin align_mask_c = 3'b001; size_strb_c = 8'h03; end
      2'b10: begin align_mask_c = 3'b011; size_strb_c = 8'h0F; end
      default: begin align_mask_c = 3'b111; size_strb_c = 8'hFF; end
    endcase
    misaligned_c = |(in_off_c & align_mask_c);
    wdata_c      = in_store_data << {in_off_c, 3'b000};
    wstrb_c      = 8'(size_strb_c << in_off_c);
  end

  // Byte-lane select and sign/zero extension of returned load data
  always_comb begin
    shifted_c = dc_resp_data >> {off_q, 3'b000};
    ext_c     = shifted_c;
    case (f3_q)
      3'b000: ext_c = {{(XLEN-8){shifted_c[7]}},   shifted_c[7:0]};
      3'b001: ext_c = {{(XLEN-16){shifted_c[15]}}, shifted_c[15:0]};
      3'b010: ext_c = {{(XLEN-32){shifted_c[31]}}, shifted_c[31:0]};
      3'b100: ext_c = {{(XLEN-8){1'b0}},           shifted_c[7:0]};
      3'b101: ext_c = {{(XLEN-16){1'b0}},          shifted_c[15:0]};
      3'b110: ext_c = {{(XLEN-32){1'b0}},          shifted_c[31:0]};
      default: ext_c = shifted_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      in_ready      <= 1'b1;
      off_q         <= '0;
      f3_q          <= '0;
      rd_q          <= '0;
      wen_q         <= 1'b0;
      is_load_q     <= 1'b0;
      alures_q      <= '0;
      dc_req_valid  <= 1'b0;
      dc_req_addr   <= '0;
      dc_req_we     <= 1'b0;
      dc_req_wdata  <= '0;
      dc_req_wstrb  <= '0;
      out_valid     <= 1'b0;
      out_lddata    <= '0;
      out_alures    <= '0;
      out_ld_or_alu <= 1'b0;
      out_rd        <= '0;
      out_wen       <= 1'b0;
      out_fault     <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_valid && in_ready) begin
            off_q     <= in_off_c;
            f3_q      <= in_funct3;
            rd_q      <= in_rd;
            wen_q     <= in_wen && !in_is_store && (in_rd != '0);
            is_load_q <= in_is_load;
            alures_q  <= in_alures;
            if (!in_is_load && !in_is_store) begin
              out_valid     <= 1'b1;
              out_alures    <= in_alures;
              out_rd        <= in_rd;
              out_wen       <= in_wen && (in_rd != '0);
              out_ld_or_alu <= 1'b0;
              out_fault     <= 1'b0;
            end else if (misaligned_c) begin
              // Faulting access never reaches the cache
              out_valid     <= 1'b1;
              out_alures    <= in_alures;
              out_rd        <= in_rd;
              out_wen       <= 1'b0;
              out_ld_or_alu <= in_is_load;
              out_fault     <= 1'b1;
            end else begin
              dc_req_valid <= 1'b1;
              dc_req_addr  <= {in_alures[XLEN-1:OFFW], 3'b000};
              dc_req_we    <= in_is_store;
              dc_req_wdata <= in_is_store ? wdata_c : '0;
              dc_req_wstrb <= in_is_store ? wstrb_c : 8'h00;
              in_ready     <= 1'b0;
              state        <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (dc_req_ready) begin
            dc_req_valid <= 1'b0;
            if (is_load_q) begin
              state <= S_WAIT;
            end else begin
              out_valid     <= 1'b1;
              out_alures    <= alures_q;
              out_rd        <= rd_q;
              out_wen       <= wen_q;
              out_ld_or_alu <= 1'b0;
              out_fault     <= 1'b0;
              state         <= S_DONE;
            end
          end
        end
        S_WAIT: begin
          if (dc_resp_valid) begin
            out_valid     <= 1'b1;
            out_lddata    <= ext_c;
            out_alures    <= alures_q;
            out_rd        <= rd_q;
            out_wen       <= wen_q;
            out_ld_or_alu <= 1'b1;
            out_fault     <= 1'b0;
            state         <= S_DONE;
          end
        end
        default: begin
          in_ready <= 1'b1;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: directed ALU, load, store, fault and reset cases.
module tb_mem_stage;

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [63:0] in_alures, in_store_data;
  logic [4:0]  in_rd;
  logic        in_wen, in_is_load, in_is_store;
  logic [2:0]  in_funct3;
  logic        dc_req_valid, dc_req_ready, dc_req_we;
  logic [63:0] dc_req_addr, dc_req_wdata;
  logic [7:0]  dc_req_wstrb;
  logic        dc_resp_valid;
  logic [63:0] dc_resp_data;
  logic        out_valid, out_ld_or_alu, out_wen, out_fault;
  logic [63:0] out_lddata, out_alures;
  logic [4:0]  out_rd;

  mem_stage #(.XLEN(64), .REGBITS(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alures(in_alures), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_wen(in_wen),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready),
    .dc_req_addr(dc_req_addr), .dc_req_we(dc_req_we),
    .dc_req_wdata(dc_req_wdata), .dc_req_wstrb(dc_req_wstrb),
    .dc_resp_valid(dc_resp_valid), .dc_resp_data(dc_resp_data),
    .out_valid(out_valid), .out_lddata(out_lddata), .out_alures(out_alures),
    .out_ld_or_alu(out_ld_or_alu), .out_rd(out_rd),
    .out_wen(out_wen), .out_fault(out_fault)
  );

  typedef struct {
    logic [63:0] lddata;
    logic        chk_ld;
    logic [63:0] alures;
    logic        ld_or_alu;
    logic [4:0]  rd;
    logic        wen;
    logic        fault;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] ld, input logic cl, input logic [63:0] alu,
                      input logic sel, input logic [4:0] rd, input logic w, input logic f);
    exp_t x;
    x.lddata = ld; x.chk_ld = cl; x.alures = alu; x.ld_or_alu = sel;
    x.rd = rd; x.wen = w; x.fault = f;
    sb.push_back(x);
  endtask

  // Monitor: every out_valid pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got 1 expected 0 at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (e.chk_ld) chk("out_lddata", out_lddata, e.lddata);
        chk("out_alures", out_alures, e.alures);
        chk("out_ld_or_alu", 64'(out_ld_or_alu), 64'(e.ld_or_alu));
        chk("out_rd", 64'(out_rd), 64'(e.rd));
        chk("out_wen", 64'(out_wen), 64'(e.wen));
        chk("out_fault", 64'(out_fault), 64'(e.fault));
      end
    end
  end

  task automatic drive(input logic ld, input logic st, input logic [63:0] a,
                       input logic [63:0] sd, input logic [2:0] f3,
                       input logic [4:0] rd, input logic w);
    chk("in_ready_idle", 64'(in_ready), 64'd1);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_alures = a;
    in_store_data = sd; in_funct3 = f3; in_rd = rd; in_wen = w;
    tick();
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
  endtask

  task automatic mem_op(input logic ld, input logic [63:0] a, input logic [63:0] sd,
                        input logic [2:0] f3, input logic [4:0] rd, input logic w,
                        input logic [63:0] xaddr, input logic [63:0] xwdata,
                        input logic [7:0] xwstrb, input int ready_dly,
                        input int resp_dly, input logic [63:0] resp);
    drive(ld, !ld, a, sd, f3, rd, w);
    for (int i = 0; i <= ready_dly; i++) begin
      chk("dc_req_valid", 64'(dc_req_valid), 64'd1);
      chk("dc_req_addr", dc_req_addr, xaddr);
      chk("dc_req_we", 64'(dc_req_we), 64'(!ld));
      if (!ld) begin
        chk("dc_req_wdata", dc_req_wdata, xwdata);
        chk("dc_req_wstrb", 64'(dc_req_wstrb), 64'(xwstrb));
      end
      chk("in_ready_busy", 64'(in_ready), 64'd0);
      if (i == ready_dly) dc_req_ready = 1'b1;
      tick();
    end
    dc_req_ready = 1'b0;
    if (ld) begin
      chk("dc_req_valid_wait", 64'(dc_req_valid), 64'd0);
      repeat (resp_dly) tick();
      dc_resp_valid = 1'b1; dc_resp_data = resp;
      tick();
      dc_resp_valid = 1'b0; dc_resp_data = '0;
    end
    chk("in_ready_done", 64'(in_ready), 64'd0);
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_alures = '0; in_store_data = '0; in_rd = '0;
    in_wen = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = '0;
    dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dc_req_valid", 64'(dc_req_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_alures", out_alures, 64'd0);
    chk("rst_out_lddata", out_lddata, 64'd0);
    chk("rst_out_wen", 64'(out_wen), 64'd0);
    chk("rst_dc_req_wstrb", 64'(dc_req_wstrb), 64'd0);

    // ALU ops back to back, second with rd=0
    push('0, 1'b0, 64'h1234, 1'b0, 5'd5, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 64'h1234, 64'd0, 3'b000, 5'd5, 1'b1);
    push('0, 1'b0, 64'h5678, 1'b0, 5'd0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 64'h5678, 64'd0, 3'b000, 5'd0, 1'b1);
    tick();

    // LB / LBU at 0x1003
    push(64'hFFFF_FFFF_FFFF_FF80, 1'b1, 64'h1003, 1'b1, 5'd7, 1'b1, 1'b0);
    mem_op(1'b1, 64'h1003, 64'd0, 3'b000, 5'd7, 1'b1, 64'h1000, 64'd0, 8'h00,
           0, 1, 64'h0000_0000_8000_0000);
    push(64'h0000_0000_0000_0080, 1'b1, 64'h1003, 1'b1, 5'd8, 1'b1, 1'b0);
    mem_op(1'b1, 64'h1003, 64'd0, 3'b100, 5'd8, 1'b1, 64'h1000, 64'd0, 8'h00,
           0, 1, 64'h0000_0000_8000_0000);

    // LW at 0x1004 (sign) and LHU at 0x1006 (zero), minimum latency
    push(64'hFFFF_FFFF_8765_4321, 1'b1, 64'h1004, 1'b1, 5'd10, 1'b1, 1'b0);
    mem_op(1'b1, 64'h1004, 64'd0, 3'b010, 5'd10, 1'b1, 64'h1000, 64'd0, 8'h00,
           0, 0, 64'h8765_4321_0000_0000);
    push(64'h0000_0000_0000_8765, 1'b1, 64'h1006, 1'b1, 5'd11, 1'b1, 1'b0);
    mem_op(1'b1, 64'h1006, 64'd0, 3'b101, 5'd11, 1'b1, 64'h1000, 64'd0, 8'h00,
           1, 0, 64'h8765_4321_0000_0000);

    // SH at 0x2006 with ready withheld 3 cycles
    push('0, 1'b0, 64'h2006, 1'b0, 5'd9, 1'b0, 1'b0);
    mem_op(1'b0, 64'h2006, 64'hBEEF, 3'b001, 5'd9, 1'b1, 64'h2000,
           64'hBEEF_0000_0000_0000, 8'hC0, 3, 0, 64'd0);

    // SD at 0x2008: full lane
    push('0, 1'b0, 64'h2008, 1'b0, 5'd12, 1'b0, 1'b0);
    mem_op(1'b0, 64'h2008, 64'h0123_4567_89AB_CDEF, 3'b011, 5'd12, 1'b1, 64'h2008,
           64'h0123_4567_89AB_CDEF, 8'hFF, 0, 0, 64'd0);

    // Misaligned LW: no request, fault pulse next cycle
    push('0, 1'b0, 64'h1002, 1'b1, 5'd3, 1'b0, 1'b1);
    drive(1'b1, 1'b0, 64'h1002, 64'd0, 3'b010, 5'd3, 1'b1);
    chk("fault_no_req", 64'(dc_req_valid), 64'd0);
    chk("fault_in_ready", 64'(in_ready), 64'd1);
    tick();

    // LD with rd=0: write enable suppressed
    push(64'h1122_3344_5566_7788, 1'b1, 64'h3000, 1'b1, 5'd0, 1'b0, 1'b0);
    mem_op(1'b1, 64'h3000, 64'd0, 3'b011, 5'd0, 1'b1, 64'h3000, 64'd0, 8'h00,
           0, 2, 64'h1122_3344_5566_7788);

    // Reset during WAIT, then a stray response
    drive(1'b1, 1'b0, 64'h3008, 64'd0, 3'b011, 5'd4, 1'b1);
    chk("rw_req_valid", 64'(dc_req_valid), 64'd1);
    dc_req_ready = 1'b1;
    tick();
    dc_req_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rw_in_ready", 64'(in_ready), 64'd1);
    chk("rw_req_dropped", 64'(dc_req_valid), 64'd0);
    dc_resp_valid = 1'b1; dc_resp_data = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    dc_resp_valid = 1'b0;
    chk("rw_no_out_valid_0", 64'(out_valid), 64'd0);
    tick();
    chk("rw_no_out_valid_1", 64'(out_valid), 64'd0);
    chk("rw_in_ready_after", 64'(in_ready), 64'd1);
    repeat (2) tick();

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
